// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - two-requester round-robin front end for one shared, externally supplied ALU.
// Operands are held at the ALU for one cycle, or MUL_LAT cycles for multiplies, and the result is registered.
module alu_share_arb #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [4:0]  req0_f,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [4:0]  req1_f,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   output logic [31:0] rsp_y,
   output logic        rsp_zero,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_f,
   input  logic [31:0] alu_y,
   input  logic        alu_zero
);

   localparam int CW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t        state_q, state_d;
   logic [31:0]   a_q, a_d, b_q, b_d;
   logic [4:0]    f_q, f_d;
   logic          gnt_q, gnt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   y_q, y_d;
   logic          zero_q, zero_d;

   logic          accept;
   logic          sel;
   logic [4:0]    sel_f;
   logic          is_mul;

   // sel=1 grants requester 1; on a tie the side not granted last wins.
   always_comb begin
      accept     = (state_q != EXEC) && (req0_valid || req1_valid);
      sel        = req1_valid && (!req0_valid || !gnt_q);
      req0_ready = accept && !sel;
      req1_ready = accept && sel;
      sel_f      = sel ? req1_f : req0_f;
      is_mul     = (sel_f[3:0] == 4'b1001) || (sel_f[3:0] == 4'b1010);
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      f_d     = f_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE, RESP: begin
            if (accept) begin
               a_d     = sel ? req1_a : req0_a;
               b_d     = sel ? req1_b : req0_b;
               f_d     = sel_f;
               gnt_d   = sel;
               cnt_d   = is_mul ? CW'(MUL_LAT) : CW'(1);
               state_d = EXEC;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               y_d     = alu_y;
               zero_d  = alu_zero;
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         f_q     <= '0;
         gnt_q   <= 1'b1;
         cnt_q   <= '0;
         y_q     <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         f_q     <= f_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         zero_q  <= zero_d;
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_f      = f_q;
   assign rsp_y      = y_q;
   assign rsp_zero   = zero_q;
   assign rsp0_valid = (state_q == RESP) && !gnt_q;
   assign rsp1_valid = (state_q == RESP) && gnt_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - scoreboard bench for alu_share_arb with a behavioural ALU.
// Drivers present queued vectors, a watcher logs handshakes, a monitor checks responses.
module tb_alu_share_arb;

   localparam int MUL_LAT = 2;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  f;
      logic [31:0] ey;
      logic        ez;
   } vec_t;

   typedef struct {
      logic        id;
      logic [31:0] y;
      logic        z;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [4:0]  req0_f = '0, req1_f = '0;
   logic        rsp0_valid, rsp1_valid, rsp_zero, alu_zero;
   logic [31:0] rsp_y, alu_a, alu_b, alu_y;
   logic [4:0]  alu_f;

   vec_t        q0[$];
   vec_t        q1[$];
   exp_t        sbq[$];
   int          gnt_log[$];
   int          rsp_cyc[$];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          chk_left = 0;
   logic [31:0] chk_a, chk_b;
   logic [4:0]  chk_f;

   alu_share_arb #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp_y(rsp_y), .rsp_zero(rsp_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
      .alu_y(alu_y), .alu_zero(alu_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU: 0000 and, 0001 or, x0011 add/sub, 1001 mul lo, 1010 signed mul hi.
   logic signed [63:0] sa, sb, prod;
   always_comb begin
      sa   = {{32{alu_a[31]}}, alu_a};
      sb   = {{32{alu_b[31]}}, alu_b};
      prod = sa * sb;
      case (alu_f[3:0])
         4'b0000: alu_y = alu_a & alu_b;
         4'b0001: alu_y = alu_a | alu_b;
         4'b0011: alu_y = alu_f[4] ? (alu_a - alu_b) : (alu_a + alu_b);
         4'b1001: alu_y = prod[31:0];
         4'b1010: alu_y = prod[63:32];
         default: alu_y = 32'h0;
      endcase
      alu_zero = (alu_y == 32'h0);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int lat_of(input logic [4:0] f);
      return (f[3:0] == 4'b1001 || f[3:0] == 4'b1010) ? MUL_LAT : 1;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            req0_valid = 1'b1; req0_a = q0[0].a; req0_b = q0[0].b; req0_f = q0[0].f;
         end else begin
            req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_f = '0;
         end
         if (q1.size() > 0) begin
            req1_valid = 1'b1; req1_a = q1[0].a; req1_b = q1[0].b; req1_f = q1[0].f;
         end else begin
            req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_f = '0;
         end
      end
   end

   // Handshake watcher: logs grants, queues expectations and checks ALU inputs hold during EXEC.
   initial begin
      vec_t v;
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            chk_left = 0;
         end else begin
            if (chk_left > 0) begin
               chk("alu_a_hold", alu_a, chk_a);
               chk("alu_b_hold", alu_b, chk_b);
               chk("alu_f_hold", {27'd0, alu_f}, {27'd0, chk_f});
               chk("ready_low_exec", {31'd0, req0_ready | req1_ready}, 32'd0);
               chk_left--;
            end
            if (req0_valid && req0_ready && req1_ready)
               chk("ready_excl", 32'd1, 32'd0);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
               e.id = req1_valid && req1_ready;
               v = e.id ? q1.pop_front() : q0.pop_front();
               e.y = v.ey;
               e.z = v.ez;
               e.cyc = cyc + 1 + lat_of(v.f);
               sbq.push_back(e);
               gnt_log.push_back(int'(e.id));
               chk_a = v.a; chk_b = v.b; chk_f = v.f;
               chk_left = lat_of(v.f);
            end
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && (rsp0_valid || rsp1_valid)) begin
            rsp_cyc.push_back(cyc);
            if (rsp0_valid && rsp1_valid)
               chk("rsp_excl", 32'd1, 32'd0);
            if (sbq.size() == 0) begin
               chk("unexpected_rsp", {31'd0, rsp1_valid}, 32'hFFFF_FFFF);
            end else begin
               e = sbq.pop_front();
               chk("rsp_id", {31'd0, rsp1_valid}, {31'd0, e.id});
               chk("rsp_y", rsp_y, e.y);
               chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.z});
               chk("rsp_cycle", cyc, e.cyc);
            end
         end
      end
   end

   task automatic push0(input logic [31:0] a, input logic [31:0] b, input logic [4:0] f,
                        input logic [31:0] ey, input logic ez);
      vec_t v;
      v.a = a; v.b = b; v.f = f; v.ey = ey; v.ez = ez;
      q0.push_back(v);
   endtask

   task automatic push1(input logic [31:0] a, input logic [31:0] b, input logic [4:0] f,
                        input logic [31:0] ey, input logic ez);
      vec_t v;
      v.a = a; v.b = b; v.f = f; v.ey = ey; v.ez = ez;
      q1.push_back(v);
   endtask

   task automatic wait_idle(input string nm);
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #3;
         if (q0.size() == 0 && q1.size() == 0 && sbq.size() == 0) return;
      end
      chk({"timeout_", nm}, 32'd1, 32'd0);
      q0.delete(); q1.delete(); sbq.delete();
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_rsp_valid"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      chk({nm, "_rsp_y"}, rsp_y, 32'd0);
      chk({nm, "_rsp_zero"}, {31'd0, rsp_zero}, 32'd0);
      chk({nm, "_alu_a"}, alu_a, 32'd0);
      chk({nm, "_alu_b"}, alu_b, 32'd0);
      chk({nm, "_alu_f"}, {27'd0, alu_f}, 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      chk("reset_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Single add, subtract-to-zero, and an out-of-range code.
      #2 push0(32'd5, 32'd7, 5'b00011, 32'd12, 1'b0);
      wait_idle("add");
      push1(32'd9, 32'd9, 5'b10011, 32'd0, 1'b1);
      wait_idle("sub");
      push0(32'd5, 32'd6, 5'b01111, 32'd0, 1'b1);
      wait_idle("bad_f");

      // Multiplies: signed high word then low word.
      push0(32'hFFFF_FFFD, 32'd4, 5'b01010, 32'hFFFF_FFFF, 1'b0);
      push0(32'hFFFF_FFFD, 32'd4, 5'b01001, 32'hFFFF_FFF4, 1'b0);
      wait_idle("mul");

      // Both requesters valid straight out of reset: alternate, back-to-back.
      @(posedge clk);
      #1 reset = 1'b1;
      gnt_log.delete();
      push0(32'd1, 32'd1, 5'b00011, 32'd2, 1'b0);
      push1(32'd8, 32'd1, 5'b00001, 32'd9, 1'b0);
      push0(32'd1, 32'd1, 5'b00011, 32'd2, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      rsp_cyc.delete();
      wait_idle("rr");
      chk("rr_grants", gnt_log.size(), 32'd3);
      if (gnt_log.size() == 3) begin
         chk("rr_g0", gnt_log[0], 32'd0);
         chk("rr_g1", gnt_log[1], 32'd1);
         chk("rr_g2", gnt_log[2], 32'd0);
      end
      chk("rr_rsps", rsp_cyc.size(), 32'd3);
      if (rsp_cyc.size() == 3) begin
         chk("rr_gap1", rsp_cyc[1] - rsp_cyc[0], 32'd2);
         chk("rr_gap2", rsp_cyc[2] - rsp_cyc[1], 32'd2);
      end

      // Reset during a multiply's EXEC: no response, outputs cleared, req0 wins next tie.
      push0(32'd6, 32'd7, 5'b01001, 32'd42, 1'b0);
      for (int i = 0; i < 50 && q0.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      sbq.delete();
      @(negedge clk);
      chk_reset_outputs("mid_reset");
      gnt_log.delete();
      push0(32'd2, 32'd3, 5'b00011, 32'd5, 1'b0);
      push1(32'd4, 32'd4, 5'b10011, 32'd0, 1'b1);
      @(posedge clk);
      #1 reset = 1'b0;
      wait_idle("post_reset");
      chk("post_reset_grants", gnt_log.size(), 32'd2);
      if (gnt_log.size() == 2) begin
         chk("post_reset_g0", gnt_log[0], 32'd0);
         chk("post_reset_g1", gnt_log[1], 32'd1);
      end

      repeat (4) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter MUL_LAT, default 2, SHALL be the number of cycles (>=1) the ALU inputs are held for multiply ops (F[3:0] = 4'b1001 or 4'b1010).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  output  1  arbiter accepts requester N this cycle.
REQ-006 reqN_a, reqN_b  input  32 each  operands from requester N.
REQ-007 reqN_f  input  5  ALU function code from requester N.
REQ-008 rspN_valid  output  1  one-cycle pulse: result for requester N is on rsp_y/rsp_zero.
REQ-009 rsp_y  output  32  registered ALU result.
REQ-010 rsp_zero  output  1  registered ALU zero flag.
REQ-011 alu_a, alu_b  output  32 each  operands driven to the shared ALU.
REQ-012 alu_f  output  5  function code driven to the shared ALU.
REQ-013 alu_y  input  32  ALU result; alu_zero  input  1  ALU zero flag.

Function
REQ-014 The block SHALL be an FSM with states IDLE, EXEC, RESP.
REQ-015 Handshake: a transfer SHALL occur on a rising edge where reqN_valid && reqN_ready; reqN_ready SHALL be high only in IDLE or RESP, and for at most one N per cycle.
REQ-016 Arbitration: if only one reqN_valid is high, that requester SHALL be granted; if both, the requester not granted last SHALL be granted (round-robin).
REQ-017 reqN_ready MAY depend combinationally on req0_valid and req1_valid; it SHALL NOT depend on operand or function inputs.
REQ-018 On transfer: a, b, f SHALL be captured into operand registers, grant id recorded, cycle counter loaded with MUL_LAT for multiply codes, else 1, and state SHALL go to EXEC.
REQ-019 alu_a/alu_b/alu_f SHALL always equal the operand registers; they SHALL NOT change in EXEC.
REQ-020 In EXEC the counter SHALL decrement each cycle; on the edge where it is 1, alu_y/alu_zero SHALL be latched into rsp_y/rsp_zero and state SHALL go to RESP.
REQ-021 In RESP rspN_valid SHALL be high for exactly one cycle for the granted N only; rsp_y/rsp_zero SHALL hold until the next latch.
REQ-022 From RESP: if a transfer occurs the FSM SHALL go to EXEC (back-to-back), else to IDLE.
REQ-023 Latency: non-multiply transfer at edge E0 SHALL give rspN_valid in the cycle after E1; multiply SHALL give it in the cycle after E(MUL_LAT).
REQ-024 Function codes F[3:0] > 4'b1010 SHALL be accepted as 1-cycle ops; the result SHALL be whatever the ALU returns (0), no error signalled.
REQ-025 Requests arriving during EXEC SHALL wait (ready low); a requester SHALL NOT be starved: a waiting valid requester SHALL be granted within two transfers.
REQ-026 Deasserting reqN_valid before transfer SHALL be legal and SHALL NOT affect state.

Reset
REQ-027 While reset is high: state=IDLE, operand registers, alu_a/alu_b/alu_f, rsp_y=0, rsp_zero=0, counter=0, rsp0_valid=rsp1_valid=0, last-grant=1 (requester 0 wins first tie).
REQ-028 Reset asserted in EXEC or RESP SHALL discard the in-flight op; no rspN_valid SHALL follow.

Verification
REQ-029 After reset, req0 a=5, b=7, f=00011 -> req0_ready=1, rsp0_valid pulse two cycles after handshake with rsp_y=12, rsp_zero=0; rsp1_valid stays 0.
REQ-030 req1 a=9, b=9, f=10011 -> rsp1_valid pulse with rsp_y=0, rsp_zero=1.
REQ-031 Both valid held high from reset, req0 f=00011 (1+1), req1 f=00001 (8|1) -> grants req0, req1, req0 alternating; rsp0 y=2, rsp1 y=9; no idle cycle between RESP and next EXEC.
REQ-032 MUL_LAT=2, req0 a=-3, b=4, f=01010 -> alu inputs stable two EXEC cycles, rsp_y=32'hFFFFFFFF one cycle later than a 1-cycle op; f=01001 -> rsp_y=32'hFFFFFFF4.
REQ-033 Reset pulsed during EXEC of a multiply -> no rsp pulse, all outputs 0, next tie granted to req0.
REQ-034 req0 f=01111 -> accepted, rsp_y=0, rsp_zero=1 after 1-cycle latency.
